// File: rtl/alu_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// alu_muldiv_sequencer
//
// Purpose:
//   Multi-cycle controller that runs LEGv8 MUL (low 64 bits, unsigned
//   shift-add) and UDIV (restoring division) on the shared 64-bit ALU.
//   While busy it owns the ALU operand, function-select and carry-in lines
//   and samples the ALU result and carry flag back every cycle. The core
//   stalls while busy is high.
//
// Optional feature:
//   ALU_MULDIV_EARLY_TERM_EN - when defined, MUL finishes as soon as the
//   multiplier register has shifted down to zero (UDIV is unaffected).
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request pulse, sampled only in IDLE
//   op           in   1   0=MUL, 1=UDIV
//   opa          in  64   multiplicand / dividend
//   opb          in  64   multiplier / divisor
//   busy         out  1   high in RUN and DONE
//   done         out  1   one-cycle pulse, result valid
//   result       out 64   product low half or quotient
//   div_by_zero  out  1   UDIV with opb==0, valid with done
//   alu_a        out 64   ALU A operand
//   alu_b        out 64   ALU B operand
//   alu_fs       out  5   ALU function select
//   alu_c0       out  1   ALU carry-in
//   alu_f        in  64   ALU result (combinational)
//   alu_status   in   4   ALU flags {V,C,N,Z}
// ---------------------------------------------------------------------------
module alu_muldiv_sequencer #(
    parameter int          ITER   = 64,
    parameter logic [4:0]  FS_ADD = 5'b01000,
    parameter logic [4:0]  FS_SUB = 5'b01010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [63:0] opa,
    input  logic [63:0] opb,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        div_by_zero,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [4:0]  alu_fs,
    output logic        alu_c0,
    input  logic [63:0] alu_f,
    input  logic [3:0]  alu_status
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic               op_q, op_d;
    // acc: P for MUL, R (remainder) for UDIV
    logic [63:0]        acc_q, acc_d;
    // m: M (shifting multiplicand) for MUL, D (divisor) for UDIV
    logic [63:0]        m_q, m_d;
    // q: Q (multiplier) for MUL, Q (dividend -> quotient) for UDIV
    logic [63:0]        q_q, q_d;
    logic [63:0]        result_q, result_d;
    logic               dbz_q, dbz_d;

    logic [63:0]        trial;
    logic               accept;
    logic               early_stop;

    // Only the carry flag takes part in the division decision.
    logic               unused_status;
    assign unused_status = ^{alu_status[3], alu_status[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            op_q      <= 1'b0;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        op_d       = op_q;
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        result_d   = result_q;
        dbz_d      = dbz_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_fs     = '0;
        alu_c0     = 1'b0;
        trial      = '0;
        accept     = 1'b0;
        early_stop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    counter_d = CNT_W'(ITER - 1);
                    dbz_d     = 1'b0;
                    acc_d     = '0;
                    if (op && (opb == 64'd0)) begin
                        // Division by zero never enters RUN.
                        state_d  = ST_DONE;
                        result_d = '0;
                        dbz_d    = 1'b1;
                        m_d      = '0;
                        q_d      = '0;
                    end else begin
                        state_d = ST_RUN;
                        m_d     = op ? opb : opa;
                        q_d     = op ? opa : opb;
                    end
                end
            end

            ST_RUN: begin
                if (!op_q) begin
                    alu_a  = acc_q;
                    alu_b  = m_q;
                    alu_fs = FS_ADD;
                    alu_c0 = 1'b0;
                    acc_d  = q_q[0] ? alu_f : acc_q;
                    m_d    = m_q << 1;
                    q_d    = q_q >> 1;
                end else begin
                    trial  = {acc_q[62:0], q_q[63]};
                    alu_a  = trial;
                    alu_b  = m_q;
                    alu_fs = FS_SUB;
                    alu_c0 = 1'b1;
                    // A set R[63] means the true 65-bit trial exceeds D even
                    // though the ALU borrow says otherwise.
                    accept = acc_q[63] | alu_status[2];
                    acc_d  = accept ? alu_f : trial;
                    q_d    = {q_q[62:0], accept};
                end

`ifdef ALU_MULDIV_EARLY_TERM_EN
                early_stop = !op_q && (q_d == 64'd0);
`else
                early_stop = 1'b0;
`endif

                if ((counter_q == '0) || early_stop) begin
                    state_d  = ST_DONE;
                    result_d = op_q ? q_d : acc_d;
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_sequencer
//
// Self-checking bench: provides a behavioural 64-bit ALU, drives directed and
// random MUL/UDIV requests and compares result, div_by_zero and latency with
// values computed from plain arithmetic (a*b, a/b).
// ---------------------------------------------------------------------------
module tb_alu_muldiv_sequencer;

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [63:0] opa;
    logic [63:0] opb;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_by_zero;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [4:0]  alu_fs;
    logic        alu_c0;
    logic [63:0] alu_f;
    logic [3:0]  alu_status;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_fs      (alu_fs),
        .alu_c0      (alu_c0),
        .alu_f       (alu_f),
        .alu_status  (alu_status)
    );

    // Behavioural ALU: only add and A+~B are needed here.
    logic [64:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        if (alu_fs == FS_ADD)
            alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {64'd0, alu_c0};
        else if (alu_fs == FS_SUB)
            alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {64'd0, alu_c0};
        alu_f      = alu_sum[63:0];
        alu_status = {alu_sum[63] ^ alu_sum[64], alu_sum[64], alu_sum[63], (alu_sum[63:0] == 64'd0)};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycles from the start-sampling edge up to and including the edge that
    // makes done visible.
    function automatic int exp_lat(input bit o, input logic [63:0] b);
        int h;
        h = 0;
        if (o && (b == 64'd0)) return 1;
`ifdef ALU_MULDIV_EARLY_TERM_EN
        if (!o) begin
            for (int i = 0; i < 64; i++) if (b[i]) h = i;
            return h + 2;
        end
`endif
        return 65;
    endfunction

    function automatic logic [63:0] exp_res(input bit o, input logic [63:0] a, input logic [63:0] b);
        if (o) return (b == 64'd0) ? 64'd0 : a / b;
        return a * b;
    endfunction

    task automatic run_op(input bit o, input logic [63:0] a, input logic [63:0] b);
        int          cyc;
        int          lat;
        logic [63:0] er;
        er  = exp_res(o, a, b);
        lat = exp_lat(o, b);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs to prove the operands were latched.
        opa = {$urandom, $urandom};
        opb = {$urandom, $urandom};
        op  = ~o;
        cyc = 1;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        if (lat > 1) begin
            check("run_fs", {59'd0, alu_fs}, o ? {59'd0, FS_SUB} : {59'd0, FS_ADD});
            check("run_c0", {63'd0, alu_c0}, {63'd0, o});
        end
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("result", result, er);
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, (o && b == 64'd0)});
        check("done_alu_a", alu_a, 64'd0);
        $display("op=%s a=%h b=%h result=%h dbz=%0d cycles=%0d", o ? "UDIV" : "MUL", a, b, result, div_by_zero, cyc);
        @(posedge clk); #1;
        check("done_pulse", {63'd0, done}, 64'd0);
        check("busy_idle", {63'd0, busy}, 64'd0);
        check("result_hold", result, er);
    endtask

    initial begin
        int          cyc;
        int          w;
        bit          o;
        logic [63:0] a;
        logic [63:0] b;

        rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_alu_a", alu_a, 64'd0);
        check("rst_alu_fs", {59'd0, alu_fs}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(1'b0, 64'd7, 64'd6);
        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_op(1'b1, 64'd100, 64'd7);
        run_op(1'b1, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        run_op(1'b1, 64'd12345, 64'd0);
        run_op(1'b0, 64'd9, 64'd9);
        run_op(1'b0, 64'd123, 64'd0);

        // Start held high through RUN and DONE: only the first op completes.
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 64'd7; opb = 64'd6;
        @(posedge clk); #1;
        cyc = 1;
        while (!done && cyc < 200) begin
            op  = $urandom_range(0, 1);
            opa = {$urandom, $urandom};
            opb = {$urandom, $urandom};
            @(posedge clk); #1;
            cyc++;
        end
        check("spam_latency", 64'(cyc), 64'(exp_lat(1'b0, 64'd6)));
        check("spam_result", result, 64'd42);
        @(posedge clk); #1;
        start = 1'b0;
        check("spam_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("spam_busy2", {63'd0, busy}, 64'd0);
        check("spam_hold", result, 64'd42);
        $display("op=MUL a=7 b=6 start held result=%h cycles=%0d", result, cyc);

        // Asynchronous reset in the middle of a long operation.
        @(negedge clk);
        start = 1'b1; op = 1'b1; opa = 64'hFFFF_0000_1234_5678; opb = 64'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #3;
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_result", result, 64'd0);
        check("arst_alu_fs", {59'd0, alu_fs}, 64'd0);
        $display("async reset mid-RUN busy=%0d result=%h", busy, result);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 64'd3, 64'd5);

        // Random operations checked against plain arithmetic.
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            w = $urandom_range(0, 64);
            b = {$urandom, $urandom};
            if (w == 0) b = 64'd0;
            else b = b >> (64 - w);
            run_op(o, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
